// File: rtl/pixel_clip_fifo_pkg.sv
// Shared screen geometry, pixel payload and clipping helper for the pixel path.
package pixel_clip_fifo_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // True when a signed drawer coordinate lies inside a w x h frame.
  function automatic logic on_screen(input logic signed [8:0] x,
                                     input logic signed [7:0] y,
                                     input int unsigned       w,
                                     input int unsigned       h);
    int xs;
    int ys;
    int ws;
    int hs;
    xs = int'(x);
    ys = int'(y);
    ws = int'(w);
    hs = int'(h);
    return (xs >= 0) && (xs < ws) && (ys >= 0) && (ys < hs);
  endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel storage: DEPTH-entry register array, one write port, one async read port.
module pixel_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_clip_fifo.sv
// Clips drawer pixels to the visible frame and buffers on-screen ones for the VGA adapter.
module pixel_clip_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SCREEN_W = pixel_clip_fifo_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = pixel_clip_fifo_pkg::SCREEN_H,
  parameter int unsigned COLOUR_W = pixel_clip_fifo_pkg::COLOUR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [8:0]         in_x,
  input  logic signed [7:0]         in_y,
  input  logic [COLOUR_W-1:0]       in_colour,
  input  logic                      in_plot,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [7:0]                vga_x,
  output logic [6:0]                vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  input  logic                      vga_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               clip_count,
  output logic                      empty
);

  import pixel_clip_fifo_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PIX_W = 8 + 7 + COLOUR_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PIX_W-1:0] wr_data;
  logic [PIX_W-1:0] rd_data;
  logic [PIX_W-1:0] hold_data;
  logic             accept;
  logic             visible;
  logic             push;
  logic             pop;

  // Handshake decode; full/empty come only from the registered level.
  assign in_ready = (level != LVL_W'(DEPTH)) && !flush;
  assign accept   = in_plot && in_ready;
  assign visible  = on_screen(in_x, in_y, SCREEN_W, SCREEN_H);
  assign push     = accept && visible;
  assign empty    = (level == '0);
  assign vga_plot = !empty;
  assign pop      = vga_plot && vga_ready && !flush;
  assign wr_data  = {in_x[7:0], in_y[6:0], in_colour};

  // Head entry falls through; an empty FIFO keeps showing the last pixel sent.
  assign {vga_x, vga_y, vga_colour} = empty ? hold_data : rd_data;

  pixel_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers and occupancy; flush empties the buffer at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Last pixel handed to the adapter, shown while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
    end else if (pop) begin
      hold_data <= rd_data;
    end
  end

  // Saturating count of accepted off-screen pixels; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (accept && !visible && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Randomised and directed bench for pixel_clip_fifo against a queue-based model.
module tb_pixel_clip_fifo;

  localparam int DEPTH = 16;

  logic              clk;
  logic              rst_n;
  logic signed [8:0] in_x;
  logic signed [7:0] in_y;
  logic [2:0]        in_colour;
  logic              in_plot;
  logic              in_ready;
  logic              flush;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              vga_plot;
  logic              vga_ready;
  logic [4:0]        level;
  logic [15:0]       clip_count;
  logic              empty;

  pixel_clip_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_plot    (in_plot),
    .in_ready   (in_ready),
    .flush      (flush),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .vga_ready  (vga_ready),
    .level      (level),
    .clip_count (clip_count),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of stored pixels plus clip count and last-sent pixel.
  logic [17:0] m_q[$];
  logic [17:0] m_last;
  int          m_clip;
  logic        m_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic plot, input int x, input int y, input int c,
                       input logic rdy, input logic fl);
    in_plot   = plot;
    in_x      = 9'(x);
    in_y      = 8'(y);
    in_colour = 3'(c);
    vga_ready = rdy;
    flush     = fl;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_clip = 0;
  endtask

  // Compare outputs mid-cycle, then advance the model across the next edge.
  task automatic cycle();
    logic [17:0] head;
    logic        exp_ready;
    int          xi;
    int          yi;
    bit          onscr;
    @(negedge clk);
    head      = (m_q.size() > 0) ? m_q[0] : m_last;
    exp_ready = (m_q.size() != DEPTH) && !flush;
    check("level", 32'(level), 32'(m_q.size()));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("vga_plot", 32'(vga_plot), 32'(m_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("vga_data", 32'({vga_x, vga_y, vga_colour}), 32'(head));
    check("clip_count", 32'(clip_count), 32'(m_clip));
    if (vga_plot && vga_ready)
      check("adapter_onscreen", 32'((vga_x < 8'd160) && (vga_y < 7'd120)), 32'd1);
    xi    = int'(in_x);
    yi    = int'(in_y);
    onscr = (xi >= 0) && (xi < 160) && (yi >= 0) && (yi < 120);
    m_acc = in_plot && exp_ready;
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && vga_ready) m_last = m_q.pop_front();
      if (m_acc) begin
        if (onscr) m_q.push_back({in_x[7:0], in_y[6:0], in_colour});
        else if (m_clip < 65535) m_clip++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 0, rdy, 1'b0);
      cycle();
    end
  endtask

  task automatic push_onscreen(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
            int'($urandom_range(0, 7)), rdy, 1'b0);
      cycle();
    end
  endtask

  // Midpoint circle points fed with hold-on-stall; clip delta must equal off-screen count.
  task automatic run_circle(input int cx, input int cy, input int diam, input bit want_clip);
    int px[$];
    int py[$];
    int r;
    int ox;
    int oy;
    int crit;
    int off;
    int idx;
    int budget;
    int clip_before;
    r = diam / 2;
    ox = r;
    oy = 0;
    crit = 1 - r;
    while (oy <= ox) begin
      px.push_back(cx + ox); py.push_back(cy + oy);
      px.push_back(cx + oy); py.push_back(cy + ox);
      px.push_back(cx - ox); py.push_back(cy + oy);
      px.push_back(cx - oy); py.push_back(cy + ox);
      px.push_back(cx - ox); py.push_back(cy - oy);
      px.push_back(cx - oy); py.push_back(cy - ox);
      px.push_back(cx + ox); py.push_back(cy - oy);
      px.push_back(cx + oy); py.push_back(cy - ox);
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
    off = 0;
    foreach (px[i])
      if (!((px[i] >= 0) && (px[i] < 160) && (py[i] >= 0) && (py[i] < 120))) off++;
    clip_before = int'(clip_count);
    idx = 0;
    budget = 4000;
    while (idx < px.size() && budget > 0) begin
      drive(1'b1, px[idx], py[idx], idx % 8, ($urandom_range(0, 3) != 0), 1'b0);
      cycle();
      if (m_acc) idx++;
      budget--;
    end
    check("circle_done", 32'(idx), 32'(px.size()));
    idle(DEPTH + 2, 1'b1);
    check("circle_clip_delta", 32'(int'(clip_count) - clip_before), 32'(off));
    if (want_clip) check("circle_clip_pos", 32'(int'(clip_count) > clip_before), 32'd1);
  endtask

  initial begin
    int clip_before;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pixel through an empty FIFO.
    drive(1'b1, 10, 20, 5, 1'b1, 1'b0);
    cycle();
    idle(1, 1'b1);
    check("single_x", 32'(vga_x), 32'd10);
    check("single_y", 32'(vga_y), 32'd20);
    idle(2, 1'b1);

    // Off-screen pixels are counted and never stored.
    clip_before = int'(clip_count);
    drive(1'b1, -1, 10, 1, 1'b1, 1'b0);  cycle();
    drive(1'b1, 160, 10, 1, 1'b1, 1'b0); cycle();
    drive(1'b1, 10, 120, 1, 1'b1, 1'b0); cycle();
    drive(1'b1, 10, -5, 1, 1'b1, 1'b0);  cycle();
    idle(1, 1'b1);
    check("clip_four", 32'(clip_count), 32'(clip_before + 4));
    check("clip_level", 32'(level), 32'd0);

    // Fill to full, offer one more, then drain in order.
    push_onscreen(DEPTH + 1, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    idle(DEPTH + 2, 1'b1);

    // Steady push+pop at level 8.
    push_onscreen(8, 1'b0);
    push_onscreen(20, 1'b1);
    check("steady_level", 32'(level), 32'd8);
    idle(DEPTH, 1'b1);

    // Flush at level 5 with a pixel offered.
    push_onscreen(5, 1'b0);
    clip_before = int'(clip_count);
    drive(1'b1, -3, 4, 2, 1'b0, 1'b1);
    cycle();
    idle(1, 1'b0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_clip", 32'(clip_count), 32'(clip_before));

    // Reset mid-stream clears everything immediately.
    push_onscreen(6, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_clip", 32'(clip_count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Circle drawer runs: centred, then mostly off the top-left corner.
    run_circle(80, 60, 80, 1'b0);
    run_circle(5, 5, 80, 1'b1);

    // Random traffic with occasional flush.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 2) != 0), int'($urandom_range(0, 200)) - 20,
            int'($urandom_range(0, 150)) - 15, int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      cycle();
    end
    idle(DEPTH + 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_clip_fifo.md
Name: pixel_clip_fifo

Overview:
Sits directly downstream of the Reuleaux-triangle / circle drawers and upstream of the VGA adapter. It accepts signed pixel coordinates from the drawer, discards off-screen pixels (160x120 frame), and buffers on-screen pixels in a small FIFO. It then drains them to the adapter under a valid/ready handshake. Drawers can then emit unclipped octant points at full rate, and clipping is kept out of every drawer.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
COLOUR_W, 3, colour width

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  asynchronous active-low reset
in_x  in  9  signed x from drawer (two's complement, -256..255)
in_y  in  8  signed y from drawer (-128..127)
in_colour  in  COLOUR_W  pixel colour
in_plot  in  1  drawer offers a pixel this cycle
in_ready  out  1  FIFO can accept a pixel this cycle
flush  in  1  synchronous discard of all buffered pixels
vga_x  out  8  unsigned x to adapter
vga_y  out  7  unsigned y to adapter
vga_colour  out  COLOUR_W  colour to adapter
vga_plot  out  1  head entry valid
vga_ready  in  1  adapter accepts head this cycle
level  out  $clog2(DEPTH)+1  entries currently stored
clip_count  out  16  pixels discarded as off-screen, saturating
empty  out  1  level == 0

Behaviour:
- Reset (async, rst_n=0): read/write pointers, level, clip_count = 0; vga_plot = 0; vga_x/vga_y/vga_colour = 0; in_ready = 1; empty = 1.
- in_ready = (level != DEPTH) && !flush. It is combinational from registered level only and never depends on in_plot or vga_ready.
- Accept: in_plot && in_ready.
- On-screen test: 0 <= in_x < SCREEN_W and 0 <= in_y < SCREEN_H, signed compares.
  - Accepted on-screen pixel: write {in_x[7:0], in_y[6:0], in_colour}.
  - Accepted off-screen pixel: not written; clip_count += 1, saturating at 16'hFFFF.
  - in_plot while in_ready=0: ignored, not counted. The drawer must hold its point.
- Output: first-word-fall-through. vga_plot = !empty. vga_x/y/colour show the head entry combinationally from storage, or hold the last value when empty.
- Pop: vga_plot && vga_ready advances the read pointer.
- Latency: an on-screen pixel accepted into an empty FIFO at edge N appears with vga_plot=1 after edge N, i.e. one cycle.
- Simultaneous push (on-screen) and pop in the same cycle: level unchanged, both pointers advance. This is legal at any level < DEPTH.
- Full (level == DEPTH): in_ready=0. A pop that cycle frees a slot, and in_ready rises the next cycle (no same-cycle pass-through).
- Pointers wrap modulo DEPTH. level is a separate up/down counter and is the only source of full/empty.
- Flush: at the next edge, pointers and level = 0 and vga_plot = 0. A pixel offered in the flush cycle is dropped and not counted. clip_count is not cleared by flush; only reset clears it.
- Reset mid-stream clears everything immediately; no partial pixel reaches the adapter.
- Internal output-side FSM is implicit via level: EMPTY (level=0) -> HOLDING (level>0) on push; HOLDING -> EMPTY on pop with no push at level 1, or on flush.

Decomposition:
- lab_pkg gains:
  - SCREEN_W/SCREEN_H constants.
  - typedef pixel_t {logic [7:0] x; logic [6:0] y; logic [COLOUR_W-1:0] colour;}.
  - function on_screen(signed x, signed y).
- One natural sub-module: pixel_fifo_mem (DEPTH x pixel_t register array, one write port, one async read port). Clipping, counters and handshake stay in the top.

Test Plan:
- Reset then push (10,20,3'b101) with vga_ready=1 -> one cycle later vga_plot=1, vga_x=10, vga_y=20, vga_colour=5; next cycle vga_plot=0, empty=1.
- Push x=-1, x=160, y=120, y=-5 (each otherwise valid) -> nothing reaches the adapter, clip_count=4, level stays 0.
- vga_ready=0, push 16 on-screen pixels -> level=16, in_ready=0. A 17th in_plot is ignored. Raise vga_ready -> 16 pixels drain in push order, one per cycle, then empty=1.
- At level=8, hold in_plot=1 (on-screen) and vga_ready=1 for 20 cycles -> level stays 8 throughout and output order is preserved.
- At level=5, assert flush for one cycle with an in_plot -> next cycle level=0, vga_plot=0, and clip_count is unchanged.
- Drive drawer with centre (80,60), diameter 80, then centre (5,5), diameter 80 -> the adapter receives only pixels with 0<=x<160 and 0<=y<120. clip_count is >0 for the second run and equals the off-screen points from the reference model.
